// File: rtl/press_decoder.sv
// Press-gesture classifier: turns a debounced level/tick pair into one registered
// single-click, double-click or long-press pulse per gesture.
module press_decoder #(
    parameter int unsigned W        = 27,
    parameter int unsigned LONG_CNT = 100_000_000,
    parameter int unsigned GAP_CNT  = 30_000_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         db_level,
    input  logic         db_tick,
    output logic         click_tick,
    output logic         dclick_tick,
    output logic         long_tick,
    output logic         busy,
    output logic [2:0]   state_dbg_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_GAP    = 3'd2,
        S_PRESS2 = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    localparam logic [W-1:0] LONG_LAST = W'(LONG_CNT - 1);
    localparam logic [W-1:0] GAP_LAST  = W'(GAP_CNT - 1);
    localparam logic [W-1:0] CNT_ONE   = W'(1);

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         click_q, click_d;
    logic         dclick_q, dclick_d;
    logic         long_q, long_d;

    // Counter restarts at 0 on every transition; exit compares fire before it could wrap.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        click_d  = 1'b0;
        dclick_d = 1'b0;
        long_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (db_tick) state_d = S_PRESS1;
            end
            S_PRESS1: begin
                if (!db_level) begin
                    state_d = S_GAP;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = S_HOLD;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_GAP: begin
                if (db_tick) begin
                    state_d = S_PRESS2;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    click_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_PRESS2: begin
                if (!db_level) begin
                    state_d  = S_IDLE;
                    dclick_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (!db_level) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            click_q  <= 1'b0;
            dclick_q <= 1'b0;
            long_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            click_q  <= click_d;
            dclick_q <= dclick_d;
            long_q   <= long_d;
        end
    end

    assign click_tick  = click_q;
    assign dclick_tick = dclick_q;
    assign long_tick   = long_q;
    assign busy        = (state_q != S_IDLE);
    assign state_dbg_o = state_q;

endmodule
